// File: rtl/axi_rd_pkg.sv
// rtl/axi_rd_pkg.sv - shared AXI read-channel types and helpers
package axi_rd_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Increment modulo n; works for non-power-of-two source counts.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/axi_rd_data_arbiter_rr.sv
// rtl/axi_rd_data_arbiter_rr.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    int          j;
    logic [W-1:0] idx;

    // Walk the request vector from ptr upward, wrapping; first hit wins.
    always_comb begin
        any     = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        j       = 0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            j   = (int'(ptr) + k) % N;
            idx = W'(j);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/axi_rd_data_arbiter.sv
// rtl/axi_rd_data_arbiter.sv - burst-granular round-robin merge of NUM_SRC R channels
module axi_rd_data_arbiter
    import axi_rd_pkg::*;
#(
    parameter  int NUM_SRC      = 4,
    parameter  int DATA_WIDTH   = 32,
    parameter  int ID_MAX_WIDTH = 12,
    localparam int SRC_W        = $clog2(NUM_SRC)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              s_rvalid,
    output logic [NUM_SRC-1:0]              s_rready,
    input  logic [NUM_SRC*ID_MAX_WIDTH-1:0] s_rid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_rdata,
    input  logic [NUM_SRC*2-1:0]            s_rresp,
    input  logic [NUM_SRC-1:0]              s_rlast,
    output logic                            m_rvalid,
    input  logic                            m_rready,
    output logic [ID_MAX_WIDTH-1:0]         m_rid,
    output logic [DATA_WIDTH-1:0]           m_rdata,
    output logic [1:0]                      m_rresp,
    output logic                            m_rlast,
    output logic [SRC_W-1:0]                m_rsrc
);

    arb_state_e                state_q;
    arb_state_e                state_d;
    logic [SRC_W-1:0]          grant;
    logic [SRC_W-1:0]          rr_ptr;
    logic                      grant_load;
    logic                      ptr_adv;

    logic                      pick_any;
    logic [NUM_SRC-1:0]        pick_gnt;
    logic [SRC_W-1:0]          pick_idx;

    logic                      slot_free;
    logic                      accept;
    logic                      sel_valid;
    logic                      sel_last;
    logic [ID_MAX_WIDTH-1:0]   sel_id;
    logic [DATA_WIDTH-1:0]     sel_data;
    resp_e                     sel_resp;

    rr_arbiter #(.N(NUM_SRC)) u_rr (
        .req     (s_rvalid),
        .ptr     (rr_ptr),
        .any     (pick_any),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

    // Only the granted source is ever muxed, so idle sources may carry junk.
    assign sel_valid = s_rvalid[grant];
    assign sel_last  = s_rlast[grant];
    assign sel_id    = s_rid[int'(grant)*ID_MAX_WIDTH +: ID_MAX_WIDTH];
    assign sel_data  = s_rdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_resp  = resp_e'(s_rresp[int'(grant)*2 +: 2]);

    // Output slot can take a beat when empty or draining this cycle.
    assign slot_free = ~m_rvalid | m_rready;
    assign accept    = (state_q == ARB_LOCKED) & sel_valid & slot_free;

    always_comb begin
        state_d    = state_q;
        grant_load = 1'b0;
        ptr_adv    = 1'b0;
        s_rready   = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_load = 1'b1;
                    state_d    = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                s_rready[grant] = slot_free;
                if (accept && sel_last) begin
                    ptr_adv = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            if (grant_load) begin
                grant <= pick_idx;
            end
            if (ptr_adv) begin
                rr_ptr <= SRC_W'(wrap_inc(32'(grant), NUM_SRC));
            end
        end
    end

    // Register slice: payload only changes on a load, so it holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rvalid <= 1'b0;
            m_rid    <= '0;
            m_rdata  <= '0;
            m_rresp  <= OKAY;
            m_rlast  <= 1'b0;
            m_rsrc   <= '0;
        end else if (accept) begin
            m_rvalid <= 1'b1;
            m_rid    <= sel_id;
            m_rdata  <= sel_data;
            m_rresp  <= sel_resp;
            m_rlast  <= sel_last;
            m_rsrc   <= grant;
        end else if (m_rready) begin
            m_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_rd_data_arbiter.sv
// tb/tb_axi_rd_data_arbiter.sv - directed and random checks for axi_rd_data_arbiter
module tb_axi_rd_data_arbiter;
    import axi_rd_pkg::*;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int IW = 12;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NS-1:0]     s_rvalid = '0;
    logic [NS-1:0]     s_rready;
    logic [NS*IW-1:0]  s_rid = '0;
    logic [NS*DW-1:0]  s_rdata = '0;
    logic [NS*2-1:0]   s_rresp = '0;
    logic [NS-1:0]     s_rlast = '0;
    logic              m_rvalid;
    logic              m_rready = 1'b0;
    logic [IW-1:0]     m_rid;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic [SW-1:0]     m_rsrc;

    always #5 clk = ~clk;

    axi_rd_data_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .ID_MAX_WIDTH(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_rvalid (s_rvalid),
        .s_rready (s_rready),
        .s_rid    (s_rid),
        .s_rdata  (s_rdata),
        .s_rresp  (s_rresp),
        .s_rlast  (s_rlast),
        .m_rvalid (m_rvalid),
        .m_rready (m_rready),
        .m_rid    (m_rid),
        .m_rdata  (m_rdata),
        .m_rresp  (m_rresp),
        .m_rlast  (m_rlast),
        .m_rsrc   (m_rsrc)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic [1:0]    resp;
        logic          last;
        logic          first;
    } beat_t;

    typedef struct {
        int    src;
        beat_t b;
        int    cyc;
    } obs_t;

    beat_t       srcq[NS][$];
    beat_t       expq[NS][$];
    obs_t        outq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          pushed = 0;
    logic [NS-1:0] s_fire = '0;
    bit          rnd_gate = 1'b0;
    int          waitc[NS];
    bit          prev_stall = 1'b0;
    logic [48:0] prev_pay = '0;
    bit          in_burst = 1'b0;
    int          burst_src = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_burst(input int src, input int len, input logic [DW-1:0] base,
                              input logic [1:0] resp);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data  = base + DW'(k);
            b.id    = IW'((src << 8) | k);
            b.resp  = resp;
            b.last  = (k == len - 1);
            b.first = (k == 0);
            srcq[src].push_back(b);
            expq[src].push_back(b);
            pushed++;
        end
    endtask

    task automatic drive();
        beat_t b;
        logic  v;
        for (int i = 0; i < NS; i++) begin
            v       = 1'b0;
            b.data  = $urandom;
            b.id    = IW'($urandom);
            b.resp  = 2'($urandom);
            b.last  = 1'($urandom);
            b.first = 1'b0;
            if (srcq[i].size() > 0 &&
                (srcq[i][0].first || !rnd_gate || $urandom_range(0, 1) == 1)) begin
                v = 1'b1;
                b = srcq[i][0];
            end
            s_rvalid[i]             = v;
            s_rdata[i*DW +: DW]     = b.data;
            s_rid[i*IW +: IW]       = b.id;
            s_rresp[i*2 +: 2]       = b.resp;
            s_rlast[i]              = b.last;
        end
    endtask

    task automatic sample();
        obs_t  o;
        beat_t e;
        s_fire = s_rvalid & s_rready;
        check("rdy_onehot", 64'($onehot0(s_rready)), 64'(1));
        if (prev_stall)
            check("stall_hold", 64'({m_rvalid, m_rsrc, m_rid, m_rdata, m_rresp, m_rlast}),
                  64'({1'b1, prev_pay}));
        prev_stall = m_rvalid & ~m_rready;
        prev_pay   = {m_rsrc, m_rid, m_rdata, m_rresp, m_rlast};
        if (prev_stall)
            check("stall_rdy", 64'(s_rready), 64'(0));
        if (m_rvalid && m_rready) begin
            o.src = int'(m_rsrc);
            o.b   = {m_rdata, m_rid, m_rresp, m_rlast, 1'b0};
            o.cyc = cyc;
            outq.push_back(o);
            if (in_burst)
                check("interleave", 64'(o.src), 64'(burst_src));
            in_burst  = !m_rlast;
            burst_src = o.src;
            if (expq[o.src].size() == 0) begin
                check("sb_extra", 64'(1), 64'(0));
            end else begin
                e = expq[o.src].pop_front();
                check("sb_beat", 64'({m_rdata, m_rid, m_rresp, m_rlast}),
                      64'({e.data, e.id, e.resp, e.last}));
            end
        end
        // A completing burst ages every other source that is still waiting.
        for (int i = 0; i < NS; i++) begin
            if (s_fire[i] && s_rlast[i]) begin
                waitc[i] = 0;
                for (int j = 0; j < NS; j++) begin
                    if (j != i && srcq[j].size() > 0) begin
                        waitc[j]++;
                        check("starve", 64'(waitc[j] <= NS - 1), 64'(1));
                    end
                end
            end
        end
    endtask

    task automatic step(input logic rdy);
        @(posedge clk);
        cyc++;
        #1 m_rready = rdy;
        @(negedge clk);
        for (int i = 0; i < NS; i++)
            if (s_fire[i]) void'(srcq[i].pop_front());
        drive();
        #1 sample();
    endtask

    task automatic flush();
        for (int i = 0; i < NS; i++) begin
            srcq[i].delete();
            expq[i].delete();
            waitc[i] = 0;
        end
        s_fire     = '0;
        prev_stall = 1'b0;
        in_burst   = 1'b0;
    endtask

    task automatic finish_reset();
        flush();
        step(1'b1);
        step(1'b1);
        rst = 1'b0;
    endtask

    task automatic wait_out(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while (outq.size() < target && n < budget) begin
            step(1'b1);
            n++;
        end
        ok = (outq.size() >= target);
        if (!ok) check("timeout", 64'(outq.size()), 64'(target));
    endtask

    initial begin
        int          base;
        int          c0;
        int          n;
        bit          ok;
        logic [3:0]  pat;
        int          exp_src[7];
        logic [31:0] exp_dat[7];
        int          left;

        for (int i = 0; i < NS; i++) waitc[i] = 0;
        rst = 1'b1;
        finish_reset();

        check("rst_mvalid", 64'(m_rvalid), 64'(0));
        check("rst_srdy",   64'(s_rready), 64'(0));
        check("rst_mdata",  64'(m_rdata),  64'(0));
        check("rst_mid",    64'(m_rid),    64'(0));
        check("rst_mresp",  64'(m_rresp),  64'(0));
        check("rst_mlast",  64'(m_rlast),  64'(0));
        check("rst_msrc",   64'(m_rsrc),   64'(0));

        // 1: src1 four-beat burst, one bubble then back-to-back beats
        base = outq.size();
        c0   = cyc;
        push_burst(1, 4, 32'h11, OKAY);
        wait_out(base + 4, 50, ok);
        if (ok) begin
            for (int k = 0; k < 4; k++) begin
                check("t1_src",  64'(outq[base+k].src),    64'(1));
                check("t1_data", 64'(outq[base+k].b.data), 64'(32'h11 + k));
                check("t1_last", 64'(outq[base+k].b.last), 64'(k == 3));
                check("t1_cyc",  64'(outq[base+k].cyc),    64'(c0 + 3 + k));
            end
        end

        // 2: src0 and src2 race from rr_ptr=0; src0 re-requests behind src2
        rst = 1'b1;
        finish_reset();
        check("t2_ptr0", 64'(dut.rr_ptr), 64'(0));
        base = outq.size();
        push_burst(0, 2, 32'h20, OKAY);
        push_burst(2, 3, 32'h40, OKAY);
        push_burst(0, 2, 32'h60, EXOKAY);
        exp_src = '{0, 0, 2, 2, 2, 0, 0};
        exp_dat = '{32'h20, 32'h21, 32'h40, 32'h41, 32'h42, 32'h60, 32'h61};
        wait_out(base + 7, 100, ok);
        if (ok) begin
            for (int k = 0; k < 7; k++) begin
                check("t2_src",  64'(outq[base+k].src),    64'(exp_src[k]));
                check("t2_data", 64'(outq[base+k].b.data), 64'(exp_dat[k]));
            end
        end

        // 3: src3 eight beats under m_rready pattern 1,0,0,1
        base = outq.size();
        pat  = 4'b1001;
        push_burst(3, 8, 32'h30, OKAY);
        n = 0;
        while (outq.size() < base + 8 && n < 120) begin
            step(pat[n % 4]);
            n++;
        end
        for (int k = 0; k < 4; k++) step(1'b1);
        check("t3_count", 64'(outq.size() - base), 64'(8));
        if (outq.size() >= base + 8) begin
            for (int k = 0; k < 8; k++) begin
                check("t3_src",  64'(outq[base+k].src),    64'(3));
                check("t3_data", 64'(outq[base+k].b.data), 64'(32'h30 + k));
            end
        end

        // 4: single-beat SLVERR burst on src0, then src1 after one idle cycle
        base = outq.size();
        push_burst(0, 1, 32'h50, SLVERR);
        push_burst(1, 2, 32'h70, OKAY);
        wait_out(base + 3, 50, ok);
        if (ok) begin
            check("t4_src0",  64'(outq[base].src),    64'(0));
            check("t4_resp",  64'(outq[base].b.resp), 64'(2'b10));
            check("t4_last",  64'(outq[base].b.last), 64'(1));
            check("t4_src1",  64'(outq[base+1].src),  64'(1));
            check("t4_gap",   64'(outq[base+1].cyc - outq[base].cyc),   64'(2));
            check("t4_b2b",   64'(outq[base+2].cyc - outq[base+1].cyc), 64'(1));
        end

        // 5: async reset after two of four beats
        base = outq.size();
        push_burst(2, 4, 32'h80, OKAY);
        wait_out(base + 2, 50, ok);
        check("t5_pre_rdy", 64'(s_rready), 64'(4'b0100));
        #1 rst = 1'b1;
        #1;
        check("t5_mvalid", 64'(m_rvalid), 64'(0));
        check("t5_srdy",   64'(s_rready), 64'(0));
        finish_reset();
        check("t5_state", 64'(dut.state_q), 64'(ARB_IDLE));
        check("t5_ptr",   64'(dut.rr_ptr),  64'(0));
        check("t5_mdata", 64'(m_rdata),     64'(0));

        // 6: random traffic with mid-burst valid drops and random backpressure
        rnd_gate = 1'b1;
        base     = outq.size();
        pushed   = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NS; i++)
                if (srcq[i].size() < 8 && $urandom_range(0, 11) == 0)
                    push_burst(i, int'($urandom_range(1, 4)), $urandom, 2'($urandom_range(0, 3)));
            step($urandom_range(0, 3) != 0);
        end
        n = 0;
        left = 1;
        while (left != 0 && n < 3000) begin
            step(1'b1);
            n++;
            left = 0;
            for (int i = 0; i < NS; i++) left += expq[i].size();
        end
        check("t6_drain", 64'(left), 64'(0));
        check("t6_beats", 64'(outq.size() - base), 64'(pushed));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
